prog_loader: RTL

Serial program loader for the 1-bit processor core. It receives instruction bytes bit-serially over a valid/ready handshake and writes them into a writable 2^N x 8 program memory. While loading, it holds the core in reset. Once the memory is full, it releases the core. It then serves `instruction` to the core from the program counter's `addr`, replacing the fixed program ROM as the writer-side counterpart of the fetch path.

---
 rtl/prog_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: bit-serial program loader for the 1-bit processor core.
// Shifts instruction bytes in MSB first over a valid/ready handshake and
// writes them into a 2^N x 8 program memory. The core is held in reset
// until the whole memory has been written. After that, the memory is served
// to the fetch path asynchronously, exactly like the ROM it replaces.
// Optional build macro: PROG_LOADER_PARITY_EN adds a 9th even-parity bit
// per frame. A frame with bad parity is not written, the sticky parity_err
// flag is set, and the same slot waits for a resend.
module prog_loader #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic         sdi,
    input  logic         bit_valid,
    output logic         bit_ready,
    input  logic [N-1:0] addr,
    output logic [7:0]   instruction,
    output logic         core_rst,
    output logic         load_done,
    output logic         parity_err
);

    localparam int DEPTH = 2 ** N;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

`ifdef PROG_LOADER_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    logic [1:0]   state_reg;
    logic [1:0]   state_next;
    logic [7:0]   shreg_reg;
    logic [3:0]   bit_cnt_reg;
    logic [N:0]   wr_ptr_reg;
    logic [N:0]   wr_ptr_inc;
    logic [7:0]   mem_reg [0:DEPTH-1];

    logic         accept;
    logic         last_bit;
    logic         commit_ok;

    assign accept     = (state_reg == ST_SHIFT) && bit_valid;
    assign last_bit   = (bit_cnt_reg == LAST_BIT);
    // The extra top bit of the write pointer flags "memory full".
    assign wr_ptr_inc = wr_ptr_reg + (N+1)'(1);

    assign bit_ready   = (state_reg == ST_SHIFT);
    assign core_rst    = (state_reg != ST_RUN);
    assign load_done   = (state_reg == ST_RUN);
    assign instruction = (state_reg == ST_RUN) ? mem_reg[addr] : 8'h00;

`ifdef PROG_LOADER_PARITY_EN
    logic par_reg;
    logic perr_reg;

    // A frame is good when the XOR of all nine received bits is zero.
    assign commit_ok  = ~par_reg;
    assign parity_err = perr_reg;

    // Running parity of the current frame, plus the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_reg  <= 1'b0;
            perr_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load_en) begin
                        par_reg <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (load_en && accept) begin
                        par_reg <= par_reg ^ sdi;
                    end
                end
                ST_COMMIT: begin
                    if (load_en) begin
                        par_reg <= 1'b0;
                        if (par_reg) begin
                            perr_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign commit_ok  = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Next-state logic; dropping load_en always wins over frame completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load_en) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!load_en) begin
                    state_next = ST_IDLE;
                end else if (accept && last_bit) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (!load_en) begin
                    state_next = ST_IDLE;
                end else if (commit_ok && wr_ptr_inc[N]) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_SHIFT;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // State register; RUN is only left through rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Shift register, counters and program memory (cleared on reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_reg   <= 8'h00;
            bit_cnt_reg <= 4'd0;
            wr_ptr_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= 8'h00;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load_en) begin
                        wr_ptr_reg  <= '0;
                        bit_cnt_reg <= 4'd0;
                    end
                end
                ST_SHIFT: begin
                    if (load_en && accept) begin
`ifdef PROG_LOADER_PARITY_EN
                        // The parity bit is not part of the data byte.
                        if (!last_bit) begin
                            shreg_reg <= {shreg_reg[6:0], sdi};
                        end
`else
                        shreg_reg <= {shreg_reg[6:0], sdi};
`endif
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    end
                end
                ST_COMMIT: begin
                    if (load_en) begin
                        bit_cnt_reg <= 4'd0;
                        if (commit_ok) begin
                            mem_reg[wr_ptr_reg[N-1:0]] <= shreg_reg;
                            wr_ptr_reg                 <= wr_ptr_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
